// File: rtl/status_pkg.sv
// Shared status-register definitions, used by the SR store path (sstat_unit)
// and by the status-load path that reads SR back onto the data bus.
package status_pkg;

  // SR bit positions
  localparam int SR_Z = 0;
  localparam int SR_C = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 3;
  localparam int SR_I = 4;

  // Default geometry and reset value
  localparam int         STATUS_SR_W     = 8;
  localparam int         STATUS_DATA_W   = 20;
  localparam logic [7:0] STATUS_SR_RESET = 8'h00;

  // Nesting state, derived from the save-stack fill level
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_NESTED = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

endpackage

// File: rtl/sr_save_stack.sv
// LIFO save stack for SR across nested interrupts. Push writes the slot at the
// current level, pop exposes the most recent entry combinationally on dout.
// Pushes into a full stack and pops from an empty stack are ignored here; the
// owner flags them as errors.
module sr_save_stack #(
  parameter int SR_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [SR_W-1:0]          din,
  output logic [SR_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SR_W-1:0] mem [DEPTH];
  logic [LW-1:0]   lvl_q;
  logic [LW-1:0]   lvl_dec;

  assign lvl_dec = lvl_q - LW'(1);
  assign full    = (lvl_q == LW'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  // Top-of-stack read; only meaningful when not empty
  assign dout    = mem[lvl_dec[AW-1:0]];

  // Stack storage and fill level; push has precedence if both are ever raised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[lvl_q[AW-1:0]] <= din;
      lvl_q              <= lvl_q + LW'(1);
    end else if (pop && !empty) begin
      lvl_q <= lvl_dec;
    end
  end

endmodule

// File: rtl/sstat_unit.sv
// Store side of the status-register path. Owns SR and updates it from the
// SSTAT bus write, ALU flag strobes, and interrupt entry/return through the
// save stack. One event takes effect per cycle, in the order
// int_entry > int_return > SSTAT > flag_we. Assumes DATA_W > SR_W.
module sstat_unit
  import status_pkg::*;
#(
  parameter int             DATA_W      = STATUS_DATA_W,
  parameter int             SR_W        = STATUS_SR_W,
  parameter int             STACK_DEPTH = 4,
  parameter logic [SR_W-1:0] WRITE_MASK = '1,
  parameter logic [SR_W-1:0] SR_RESET   = SR_W'(STATUS_SR_RESET)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           flag_we,
  input  logic [SR_W-1:0]                flag_mask,
  input  logic [SR_W-1:0]                flag_val,
  input  logic                           int_entry,
  input  logic                           int_return,
  output logic [SR_W-1:0]                status_register,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           err_width,
  output logic                           err_ovf,
  output logic                           err_unf
);

  // Masked merge: bits set in mask take the new value, others keep the old
  function automatic logic [SR_W-1:0] merge(input logic [SR_W-1:0] old_v,
                                            input logic [SR_W-1:0] new_v,
                                            input logic [SR_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [SR_W-1:0] sr_p1;
  logic            ready_p1;
  logic            err_width_p1;
  logic            err_ovf_p1;
  logic            err_unf_p1;

  logic [SR_W-1:0] sr_next;
  logic            push;
  logic            pop;
  logic            set_ovf;
  logic            set_unf;
  logic            width_bad;
  logic            wr_fire;
  logic            stk_full;
  logic            stk_empty;
  logic [SR_W-1:0] stk_top;
  logic [1:0]      state;

  sr_save_stack #(
    .SR_W  (SR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sr_p1),
    .dout  (stk_top),
    .level (stack_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Interrupt events own the cycle, so SSTAT is back-pressured while they are up
  assign wr_ready = ready_p1 && !int_entry && !int_return;
  assign wr_fire  = wr_valid && wr_ready;

  // Nesting state derived from the stack fill level
  always_comb begin
    state = ST_NESTED;
    if (stk_empty)     state = ST_IDLE;
    else if (stk_full) state = ST_FULL;
  end

  // Priority mux selecting the single SR update for this cycle
  always_comb begin
    sr_next   = sr_p1;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    width_bad = 1'b0;
    if (int_entry) begin
      // I is cleared even when the save is lost to overflow
      push          = (state != ST_FULL);
      set_ovf       = (state == ST_FULL);
      sr_next[SR_I] = 1'b0;
    end else if (int_return) begin
      if (state == ST_IDLE) begin
        set_unf = 1'b1;
      end else begin
        pop     = 1'b1;
        sr_next = stk_top;
      end
    end else if (wr_fire) begin
      sr_next   = merge(sr_p1, data_in[SR_W-1:0], WRITE_MASK);
      width_bad = |data_in[DATA_W-1:SR_W];
    end else if (flag_we) begin
      sr_next = merge(sr_p1, flag_val, flag_mask);
    end
  end

  // SR register, ready flag and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_p1        <= SR_RESET;
      ready_p1     <= 1'b0;
      err_width_p1 <= 1'b0;
      err_ovf_p1   <= 1'b0;
      err_unf_p1   <= 1'b0;
    end else begin
      sr_p1        <= sr_next;
      ready_p1     <= 1'b1;
      err_width_p1 <= width_bad;
      err_ovf_p1   <= err_ovf_p1 | set_ovf;
      err_unf_p1   <= err_unf_p1 | set_unf;
    end
  end

  assign status_register = sr_p1;
  assign err_width       = err_width_p1;
  assign err_ovf         = err_ovf_p1;
  assign err_unf         = err_unf_p1;

endmodule

// File: tb/tb_sstat_unit.sv
// Bench for sstat_unit: directed steps followed by random traffic, all checked
// against a queue-based model of the status register and its save stack.
module tb_sstat_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] data_in;
  logic        flag_we;
  logic [7:0]  flag_mask;
  logic [7:0]  flag_val;
  logic        int_entry;
  logic        int_return;
  logic [7:0]  status_register;
  logic [2:0]  stack_level;
  logic        err_width;
  logic        err_ovf;
  logic        err_unf;

  sstat_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .data_in         (data_in),
    .flag_we         (flag_we),
    .flag_mask       (flag_mask),
    .flag_val        (flag_val),
    .int_entry       (int_entry),
    .int_return      (int_return),
    .status_register (status_register),
    .stack_level     (stack_level),
    .err_width       (err_width),
    .err_ovf         (err_ovf),
    .err_unf         (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] m_sr;
  logic [7:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;
  logic       m_errw;
  logic       m_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr   = 8'h00;
    m_stk.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_errw = 1'b0;
    m_rdy  = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_sr"},   32'(status_register), 32'(m_sr));
    chk({tag, "_lvl"},  32'(stack_level),     32'(m_stk.size()));
    chk({tag, "_errw"}, 32'(err_width),       32'(m_errw));
    chk({tag, "_ovf"},  32'(err_ovf),         32'(m_ovf));
    chk({tag, "_unf"},  32'(err_unf),         32'(m_unf));
  endtask

  // One clock cycle: called #1 after a rising edge, returns #1 after the next
  task automatic cyc(input string tag, input logic ie, input logic ir,
                     input logic wv, input logic [19:0] din,
                     input logic fw, input logic [7:0] fm, input logic [7:0] fv,
                     output logic accepted);
    logic exp_rdy;
    int_entry  = ie;
    int_return = ir;
    wr_valid   = wv;
    data_in    = din;
    flag_we    = fw;
    flag_mask  = fm;
    flag_val   = fv;
    #1;
    exp_rdy = m_rdy && !ie && !ir;
    chk({tag, "_rdy"}, 32'(wr_ready), 32'(exp_rdy));
    accepted = wv && exp_rdy;
    m_errw   = 1'b0;
    if (ie) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else m_stk.push_back(m_sr);
      m_sr[4] = 1'b0;
    end else if (ir) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_sr = m_stk.pop_back();
    end else if (accepted) begin
      m_sr   = din[7:0];
      m_errw = (din[19:8] != 12'h000);
    end else if (fw) begin
      m_sr = (m_sr & ~fm) | (fv & fm);
    end
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic idle(input string tag);
    logic a;
    cyc(tag, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h00, 8'h00, a);
  endtask

  task automatic sstat(input string tag, input logic [19:0] din);
    logic a;
    cyc(tag, 1'b0, 1'b0, 1'b1, din, 1'b0, 8'h00, 8'h00, a);
  endtask

  initial begin
    logic acc;
    rst_n      = 1'b1;
    wr_valid   = 1'b0;
    data_in    = '0;
    flag_we    = 1'b0;
    flag_mask  = '0;
    flag_val   = '0;
    int_entry  = 1'b0;
    int_return = 1'b0;
    model_reset();

    // Reset asserted mid-cycle takes effect immediately
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sr",   32'(status_register), 32'h00);
    chk("rst_lvl",  32'(stack_level),     32'h0);
    chk("rst_errs", 32'({err_width, err_ovf, err_unf}), 32'h0);
    chk("rst_rdy",  32'(wr_ready),        32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle("first_edge");

    // SSTAT writes, with and without nonzero upper bits
    sstat("t2a", 20'h000A5);
    chk("t2a_const", 32'(status_register), 32'hA5);
    sstat("t2b", 20'h3F0C1);
    chk("t2b_const", 32'({status_register, err_width}), 32'h183);
    idle("t2c");
    chk("t2c_pulse_end", 32'(err_width), 32'h0);

    // ALU flag update, and SSTAT overriding a same-cycle flag update
    sstat("t3a", 20'h00010);
    cyc("t3b", 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 8'h0F, 8'h03, acc);
    chk("t3b_const", 32'(status_register), 32'h13);
    cyc("t3c", 1'b0, 1'b0, 1'b1, 20'h00055, 1'b1, 8'hFF, 8'h00, acc);
    chk("t3c_const", 32'(status_register), 32'h55);

    // Nested entry/return restores SR
    sstat("t4a", 20'h0001F);
    cyc("t4e1", 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    cyc("t4e2", 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    chk("t4e_const", 32'({status_register, 5'(stack_level)}), 32'({8'h0F, 5'd2}));
    cyc("t4r1", 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    chk("t4r1_const", 32'(status_register), 32'h0F);
    cyc("t4r2", 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    chk("t4r2_const", 32'(status_register), 32'h1F);

    // Overflow then underflow
    sstat("t5a", 20'h0009A);
    for (int i = 0; i < 5; i++)
      cyc("t5e", 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    chk("t5e_const", 32'({5'(stack_level), err_ovf}), 32'({5'd4, 1'b1}));
    for (int i = 0; i < 5; i++)
      cyc("t5r", 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);
    chk("t5r_const", 32'({status_register, 3'(stack_level), err_unf}), 32'({8'h9A, 3'd0, 1'b1}));

    // SSTAT held off by an interrupt, accepted on the following cycle
    cyc("t6a", 1'b1, 1'b0, 1'b1, 20'h00033, 1'b0, 8'h0, 8'h0, acc);
    chk("t6a_held", 32'(acc), 32'h0);
    cyc("t6b", 1'b0, 1'b0, 1'b1, 20'h00033, 1'b0, 8'h0, 8'h0, acc);
    chk("t6b_const", 32'(status_register), 32'h33);
    cyc("t6c", 1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 8'h0, 8'h0, acc);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [19:0] d;
      int r;
      r = int'($urandom_range(0, 9));
      d = 20'($urandom);
      if ($urandom_range(0, 1) == 0) d[19:8] = '0;
      cyc("rnd", r == 0 || r == 9, r == 1 || r == 9, $urandom_range(0, 2) == 0, d,
          $urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), acc);
    end

    // Reset in the middle of activity discards stack and errors
    for (int i = 0; i < 3; i++)
      cyc("pre_rst", 1'b1, 1'b0, 1'b1, 20'h7FF44, 1'b0, 8'h0, 8'h0, acc);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_state("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("post_rst");
    sstat("post_rst_wr", 20'h000E7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
